// File: rtl/i2c_slave_regif.sv
// I2C target with an 8-bit register-file port: pointer byte, auto-incrementing writes and reads.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave_regif #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         PTR_W      = 3
) (
    input  logic             wb_clk_i,
    input  logic             arst_i,
    input  logic             scl_pad_i,
    input  logic             sda_pad_i,
    output logic             sda_pad_o,
    output logic             sda_padoen_o,
    output logic [PTR_W-1:0] reg_addr_o,
    output logic [7:0]       reg_wdata_o,
    output logic             reg_wr_o,
    input  logic [7:0]       reg_rdata_i,
    output logic             busy_o
);
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_PTR      = 4'd3;
    localparam logic [3:0] ST_DATA_WR  = 4'd4;
    localparam logic [3:0] ST_WR_ACK   = 4'd5;
    localparam logic [3:0] ST_DATA_RD  = 4'd6;
    localparam logic [3:0] ST_RD_ACK   = 4'd7;
    localparam logic [3:0] ST_IGNORE   = 4'd8;

    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic r_scl_d, r_sda_d;
    logic w_scl, w_sda;

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_pad_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_pad_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] r_scl_h, r_sda_h;
    logic       r_scl_m, r_sda_m;

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_scl_h <= 2'b11;
            r_sda_h <= 2'b11;
            r_scl_m <= 1'b1;
            r_sda_m <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[0], r_scl_s2};
            r_sda_h <= {r_sda_h[0], r_sda_s2};
            r_scl_m <= (r_scl_h[1] & r_scl_h[0]) | (r_scl_h[1] & r_scl_s2) | (r_scl_h[0] & r_scl_s2);
            r_sda_m <= (r_sda_h[1] & r_sda_h[0]) | (r_sda_h[1] & r_sda_s2) | (r_sda_h[0] & r_sda_s2);
        end
    end
    assign w_scl = r_scl_m;
    assign w_sda = r_sda_m;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    logic [3:0]       r_state, r_bit_cnt;
    logic [7:0]       r_shift, r_wdata;
    logic [PTR_W-1:0] r_ptr;
    logic             r_oen, r_wr, r_busy, r_rw, r_nack;

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_wdata   <= 8'h00;
            r_ptr     <= '0;
            r_oen     <= 1'b1;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
            r_wr    <= 1'b0;
            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_oen     <= 1'b1;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 4'd0;
                r_oen     <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_rw <= r_shift[0];
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                r_state <= ST_ADDR_ACK;
                                r_oen   <= 1'b0;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            if (r_rw) begin
                                r_state <= ST_DATA_RD;
                                r_shift <= reg_rdata_i;
                                r_oen   <= reg_rdata_i[7];
                            end else begin
                                r_state <= ST_PTR;
                                r_oen   <= 1'b1;
                            end
                        end
                    end
                    // Count 9 marks the pointer ACK slot; no separate state for it.
                    ST_PTR: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_ptr     <= r_shift[PTR_W-1:0];
                            r_oen     <= 1'b0;
                            r_bit_cnt <= 4'd9;
                        end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                            r_oen     <= 1'b1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_DATA_WR;
                        end
                    end
                    ST_DATA_WR: begin
                        if (w_scl_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_wr    <= 1'b1;
                                r_wdata <= {r_shift[6:0], w_sda};
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_state <= ST_WR_ACK;
                            r_oen   <= 1'b0;
                        end
                    end
                    ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_oen     <= 1'b1;
                            r_ptr     <= r_ptr + PTR_ONE;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_DATA_WR;
                        end
                    end
                    ST_DATA_RD: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_oen     <= 1'b1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_RD_ACK;
                        end else if (w_scl_fall) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_oen   <= r_shift[6];
                        end
                    end
                    // Pointer moves on the ACK rise so the next capture sees the new address.
                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_nack <= w_sda;
                            if (!w_sda) r_ptr <= r_ptr + PTR_ONE;
                        end else if (w_scl_fall) begin
                            if (r_nack) begin
                                r_state <= ST_IGNORE;
                            end else begin
                                r_state <= ST_DATA_RD;
                                r_shift <= reg_rdata_i;
                                r_oen   <= reg_rdata_i[7];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = r_oen;
    assign reg_addr_o   = r_ptr;
    assign reg_wdata_o  = r_wdata;
    assign reg_wr_o     = r_wr;
    assign busy_o       = r_busy;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// Scoreboard bench for i2c_slave_regif: a bit-banged master pushes expected SDA drive and
// register writes into queues; monitor processes pop and compare as the DUT responds.
module tb_i2c_slave_regif;
    logic       wb_clk_i = 1'b0;
    logic       arst_i   = 1'b1;
    logic       m_scl    = 1'b1;
    logic       m_sda    = 1'b1;
    logic       sda_pad_o, sda_padoen_o, reg_wr_o, busy_o;
    logic [2:0] reg_addr_o;
    logic [7:0] reg_wdata_o, reg_rdata_i;

    int checks = 0;
    int errors = 0;

    logic        exp_oen_q[$];
    logic [10:0] exp_wr_q[$];
    event        ev_sample;

    always #5 wb_clk_i = ~wb_clk_i;

    i2c_slave_regif #(.SLAVE_ADDR(7'h50), .PTR_W(3)) dut (
        .wb_clk_i    (wb_clk_i),
        .arst_i      (arst_i),
        .scl_pad_i   (m_scl),
        .sda_pad_i   (m_sda),
        .sda_pad_o   (sda_pad_o),
        .sda_padoen_o(sda_padoen_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wr_o    (reg_wr_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o)
    );

    always_comb begin
        case (reg_addr_o)
            3'd7:    reg_rdata_i = 8'h11;
            3'd0:    reg_rdata_i = 8'h22;
            default: reg_rdata_i = 8'h00;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    // SDA drive monitor: one expectation per SCL high phase of a data/ACK clock.
    initial begin
        logic e;
        forever begin
            @(ev_sample);
            checks++;
            if (exp_oen_q.size() == 0) begin
                errors++;
                $display("FAIL oen_unexpected_sample actual=%0b", sda_padoen_o);
            end else begin
                e = exp_oen_q.pop_front();
                if (sda_padoen_o !== e) begin
                    errors++;
                    $display("FAIL oen_bit actual=%0b expected=%0b", sda_padoen_o, e);
                end
            end
        end
    end

    // Register write monitor.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge wb_clk_i);
            if (reg_wr_o) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected actual addr=%0h data=%0h", reg_addr_o, reg_wdata_o);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({reg_addr_o, reg_wdata_o} !== e) begin
                        errors++;
                        $display("FAIL wr_event actual addr=%0h data=%0h expected addr=%0h data=%0h",
                                 reg_addr_o, reg_wdata_o, e[10:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; clks(6);
        m_scl = 1'b1; clks(6);
        m_sda = 1'b0; clks(6);
        m_scl = 1'b0; clks(6);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; clks(6);
        m_scl = 1'b1; clks(6);
        m_sda = 1'b1; clks(8);
    endtask

    task automatic i2c_bit(input logic b, input logic exp_oen);
        m_sda = b; clks(6);
        exp_oen_q.push_back(exp_oen);
        m_scl = 1'b1; clks(4);
        ->ev_sample;
        clks(4);
        m_scl = 1'b0; clks(6);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack_oen);
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], 1'b1);
        i2c_bit(1'b1, exp_ack_oen);
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic m_ack);
        for (int i = 7; i >= 0; i--) i2c_bit(1'b1, exp_d[i]);
        i2c_bit(m_ack, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oen"},   sda_padoen_o, 1);
        chk({tag, "_pad_o"}, sda_pad_o,    0);
        chk({tag, "_wr"},    reg_wr_o,     0);
        chk({tag, "_addr"},  reg_addr_o,   0);
        chk({tag, "_wdata"}, reg_wdata_o,  0);
        chk({tag, "_busy"},  busy_o,       0);
    endtask

    initial begin
        clks(4);
        chk_reset_outputs("por");
        arst_i = 1'b0;
        clks(10);

        // Pointer write then one data write; pointer advances past the written slot.
        i2c_start();
        chk("busy_after_start", busy_o, 1);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h03, 1'b0);
        exp_wr_q.push_back({3'd3, 8'h5A});
        send_byte(8'h5A, 1'b0);
        i2c_stop();
        chk("ptr_after_write", reg_addr_o, 4);
        chk("busy_after_stop", busy_o, 0);

        // Foreign address: never ACKed, bus busy until STOP.
        i2c_start();
        send_byte(8'hA2, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("busy_ignore", busy_o, 1);
        chk("oen_ignore", sda_padoen_o, 1);
        i2c_stop();
        chk("busy_ignore_stop", busy_o, 0);
        chk("ptr_ignore_kept", reg_addr_o, 4);

        // Pointer 7, repeated START, read two bytes across the wrap.
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h07, 1'b0);
        chk("ptr_loaded_7", reg_addr_o, 7);
        i2c_start();
        send_byte(8'hA1, 1'b0);
        read_byte(8'h11, 1'b0);
        chk("ptr_wrapped_0", reg_addr_o, 0);
        read_byte(8'h22, 1'b1);
        i2c_stop();
        chk("ptr_after_nack", reg_addr_o, 0);

        // Reset pulse during the 4th data bit.
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 3; i++) i2c_bit(1'b1, 1'b1);
        m_sda = 1'b1; clks(6);
        m_scl = 1'b1; clks(3);
        arst_i = 1'b1; clks(1);
        chk_reset_outputs("mid_rst");
        arst_i = 1'b0; clks(4);
        m_scl = 1'b0; clks(6);

        // Fresh transaction after reset, then STOP while slave drives a 0 in DATA_RD.
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h02, 1'b0);
        i2c_start();
        send_byte(8'hA1, 1'b0);
        i2c_bit(1'b1, 1'b0);
        i2c_bit(1'b1, 1'b0);
        chk("oen_driving_before_stop", sda_padoen_o, 0);
        i2c_stop();
        chk("oen_after_rd_stop", sda_padoen_o, 1);
        chk("busy_after_rd_stop", busy_o, 0);
        chk("ptr_after_rd_stop", reg_addr_o, 2);

        // One-cycle SCL glitch (SDA=1) in DATA_WR ahead of byte 0x00.
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h05, 1'b0);
        m_sda = 1'b1; clks(6);
        m_scl = 1'b1; clks(1);
        m_scl = 1'b0; clks(6);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        exp_wr_q.push_back({3'd5, 8'h00});
        send_byte(8'h00, 1'b0);
`else
        exp_wr_q.push_back({3'd5, 8'h80});
        for (int i = 0; i < 7; i++) i2c_bit(1'b0, 1'b1);
        i2c_bit(1'b0, 1'b0);
        i2c_bit(1'b1, 1'b1);
`endif
        i2c_stop();
        chk("ptr_after_glitch", reg_addr_o, 6);

        clks(10);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("oen_queue_drained", exp_oen_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
